// File: rtl/mu0_io_defs.sv
// Shared definitions for the MU0 I/O port.
// Offsets within the window, STATUS and CTRL bit positions.
package mu0_io_defs;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_FULL  = 3;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/mu0_sync_fifo.sv
// Synchronous FIFO with push/pop/flush.
// A push at full succeeds only when a pop frees a slot that cycle.
module mu0_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointers, count and storage; flush wins over push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    overflow = 1'b0;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      overflow = push & ~do_push;
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      if (do_push & ~do_pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (do_pop & ~do_push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mu0_io_port.sv
// MU0 memory-bus stage: RAM pass-through plus a 4-word I/O window
// holding a TX FIFO, STATUS, an RX holding register and CTRL.
module mu0_io_port
  import mu0_io_defs::*;
#(
  parameter logic [11:0] IO_BASE  = 12'hFF0,
  parameter int          TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [15:0] cpu_data_in,
  output logic [11:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic        io_sel;
  logic [1:0]  off;
  logic        io_wr;
  logic        io_rd;
  logic        off_st;
  logic        off_rx;
  logic        tx_push;
  logic        ctrl_wr;
  logic        tx_flush;
  logic        clr_ovf;
  logic        rx_rd;
  logic        rx_cap;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_ovf_ev;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [15:0] io_rdata;

  logic        ovf_q, ovf_d;
  logic        rx_full_q, rx_full_d;
  logic [15:0] rx_hold_q, rx_hold_d;

  assign io_sel      = (cpu_address[11:2] == IO_BASE[11:2]);
  assign off         = cpu_address[1:0];
  assign mem_address = cpu_address;
  assign mem_wdata   = cpu_data_out;
  assign mem_read    = cpu_read & ~io_sel;
  assign mem_write   = cpu_write & ~io_sel;

  assign io_wr    = cpu_write & io_sel;
  assign io_rd    = cpu_read & io_sel;
  assign off_st   = (off == OFF_STATUS);
  assign off_rx   = (off == OFF_RXDATA);
  assign tx_push  = io_wr & (off == OFF_TXDATA);
  assign ctrl_wr  = io_wr & (off == OFF_CTRL);
  assign tx_flush = ctrl_wr & cpu_data_out[CTRL_FLUSH];
  assign clr_ovf  = ctrl_wr & cpu_data_out[CTRL_CLR_OVF];
  assign rx_rd    = io_rd & off_rx;

  assign tx_valid = |tx_count;
  assign rx_ready = ~rx_full_q | rx_rd;
  assign rx_cap   = rx_valid & rx_ready;

  mu0_sync_fifo #(
    .W     (16),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .pop      (tx_valid & tx_ready),
    .flush    (tx_flush),
    .wdata    (cpu_data_out),
    .rdata    (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count),
    .overflow (tx_ovf_ev)
  );

  // Register-map read mux
  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      off_st: begin
        io_rdata[ST_TX_EMPTY] = tx_empty;
        io_rdata[ST_TX_FULL]  = tx_full;
        io_rdata[ST_TX_OVF]   = ovf_q;
        io_rdata[ST_RX_FULL]  = rx_full_q;
      end
      off_rx:  io_rdata = rx_full_q ? rx_hold_q : '0;
      default: io_rdata = '0;
    endcase
  end

  assign cpu_data_in = io_sel ? io_rdata : mem_rdata;

  // Sticky overflow and RX holding register next state
  always_comb begin
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (tx_ovf_ev) begin
      ovf_d = 1'b1;
    end
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end else if (rx_rd) begin
      rx_full_d = 1'b0;
      rx_hold_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
    end
  end

endmodule

// File: tb/tb_mu0_io_port.sv
// Directed bench for mu0_io_port.
// Expected words are queued when driven and popped when observed.
module tb_mu0_io_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] cpu_address = '0;
  logic [15:0] cpu_data_out = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_data_in;
  logic [11:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata = '0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int checks = 0;
  int failures = 0;

  logic [15:0] txq[$];
  logic [15:0] rdq[$];

  mu0_io_port dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_data_in  (cpu_data_in),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d);
    cpu_address = a;
    cpu_data_out = d;
    cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
  endtask

  task automatic tx_wr(input logic [15:0] d);
    if (txq.size() < 4) txq.push_back(d);
    cpu_wr(12'hFF0, d);
  endtask

  task automatic cpu_rd(input string tag, input logic [11:0] a,
                        input logic [15:0] exp);
    rdq.push_back(exp);
    cpu_address = a;
    cpu_read = 1'b1;
    #1;
    chk(tag, cpu_data_in, rdq.pop_front());
    step();
    cpu_read = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    chk("rst_tx_data", tx_data, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1: pass-through and STATUS after reset
    mem_rdata = 16'hBEEF;
    cpu_address = 12'h010;
    cpu_read = 1'b1;
    #1;
    chk("ram_mem_read", {15'd0, mem_read}, 16'd1);
    cpu_read = 1'b0;
    cpu_rd("ram_rdata", 12'h010, 16'hBEEF);
    cpu_address = 12'hFF1;
    cpu_read = 1'b1;
    #1;
    chk("io_mem_read", {15'd0, mem_read}, 16'd0);
    cpu_read = 1'b0;
    cpu_rd("status_reset", 12'hFF1, 16'h0001);

    // 2: fill FIFO then overflow
    tx_ready = 1'b0;
    tx_wr(16'h1111);
    chk("tx_valid_1", {15'd0, tx_valid}, 16'd1);
    chk("tx_head_1", tx_data, txq[0]);
    cpu_rd("status_one", 12'hFF1, 16'h0000);
    tx_wr(16'h2222);
    tx_wr(16'h3333);
    tx_wr(16'h4444);
    cpu_rd("status_full", 12'hFF1, 16'h0002);
    tx_wr(16'h5555);
    cpu_rd("status_ovf", 12'hFF1, 16'h0006);
    chk("tx_head_ovf", tx_data, txq[0]);

    // 3: drain
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", {15'd0, tx_valid}, 16'd1);
      chk("drain_data", tx_data, txq.pop_front());
      step();
    end
    tx_ready = 1'b0;
    chk("drain_empty", {15'd0, tx_valid}, 16'd0);
    cpu_rd("status_drained", 12'hFF1, 16'h0005);
    cpu_wr(12'hFF3, 16'h0001);
    cpu_rd("status_clr", 12'hFF1, 16'h0001);

    // 4: push with pop at one entry and at full
    tx_wr(16'h7777);
    txq.push_back(16'hAAAA);
    tx_ready = 1'b1;
    chk("pp1_head", tx_data, txq.pop_front());
    cpu_wr(12'hFF0, 16'hAAAA);
    tx_ready = 1'b0;
    chk("pp1_next", tx_data, txq[0]);
    cpu_rd("pp1_status", 12'hFF1, 16'h0000);
    tx_ready = 1'b1;
    void'(txq.pop_front());
    step();
    tx_ready = 1'b0;
    chk("pp1_count", {15'd0, tx_valid}, 16'd0);
    tx_wr(16'h0101);
    tx_wr(16'h0202);
    tx_wr(16'h0303);
    tx_wr(16'h0404);
    tx_ready = 1'b1;
    chk("ppf_head", tx_data, txq.pop_front());
    txq.push_back(16'h0505);
    cpu_wr(12'hFF0, 16'h0505);
    tx_ready = 1'b0;
    cpu_rd("ppf_status", 12'hFF1, 16'h0002);
    chk("ppf_next", tx_data, txq[0]);
    cpu_wr(12'hFF3, 16'h0002);
    txq.delete();
    chk("flush_valid", {15'd0, tx_valid}, 16'd0);
    cpu_rd("flush_status", 12'hFF1, 16'h0001);

    // 5: RX holding register
    rx_data = 16'h00C3;
    rx_valid = 1'b1;
    #1;
    chk("rx_ready_empty", {15'd0, rx_ready}, 16'd1);
    step();
    rx_valid = 1'b0;
    chk("rx_ready_full", {15'd0, rx_ready}, 16'd0);
    cpu_rd("rx_status", 12'hFF1, 16'h0009);
    rx_data = 16'h00C4;
    rx_valid = 1'b1;
    cpu_address = 12'hFF2;
    cpu_read = 1'b1;
    #1;
    chk("rx_cut_ready", {15'd0, rx_ready}, 16'd1);
    cpu_read = 1'b0;
    cpu_rd("rx_old_word", 12'hFF2, 16'h00C3);
    rx_valid = 1'b0;
    cpu_rd("rx_still_full", 12'hFF1, 16'h0009);
    cpu_rd("rx_new_word", 12'hFF2, 16'h00C4);
    cpu_rd("rx_status_clr", 12'hFF1, 16'h0001);
    cpu_rd("rx_empty_read", 12'hFF2, 16'h0000);

    // 6: asynchronous reset mid-drain
    tx_wr(16'h0A0A);
    tx_wr(16'h0B0B);
    tx_wr(16'h0C0C);
    tx_wr(16'h0D0D);
    rx_data = 16'h0055;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    chk("mid_head", tx_data, txq.pop_front());
    step();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("mid_rx_ready", {15'd0, rx_ready}, 16'd0);
    #2;
    rst = 1'b0;
    #1;
    txq.delete();
    chk("arst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("arst_rx_ready", {15'd0, rx_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    cpu_rd("arst_status", 12'hFF1, 16'h0001);
    cpu_rd("arst_rxdata", 12'hFF2, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
